// File: rtl/mul_shift_add_ctrl.sv
// -----------------------------------------------------------------------------
// mul_shift_add_ctrl
//   Sequential shift-and-add multiplier with its own controller. Operand A and
//   then operand B arrive over one shared bus, each qualified by in_valid. In
//   signed mode the operands are converted to magnitudes and the sign is
//   applied to the full-width product at the end. The loop stops as soon as
//   the remaining multiplier bits are all zero. The product is a full 2*WIDTH
//   bits wide, so nothing is truncated.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a multiply; accepted in IDLE only
//   signed_en    1 = two's-complement operands; sampled together with start
//   in_valid     data_in carries an operand this cycle (LDA / LDB only)
//   data_in      shared operand bus: A first, then B
//   busy         high in LDA, LDB, CALC and FIX
//   done         one-cycle pulse in DONE; product is valid
//   product      result; held until the next operation enters LDA
//   dbg_state_o  current FSM state, for checkers and debug
//
// Handshake: an operand is transferred on any rising edge where the FSM is in
// LDA (for A) or LDB (for B) and in_valid is high. There is no ready signal;
// the block is always ready in those two states and ignores in_valid in every
// other state.
// -----------------------------------------------------------------------------
module mul_shift_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_en,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2:0]           dbg_state_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDA  = 3'd1;
  localparam logic [2:0] S_LDB  = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               mode_q, mode_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [2*WIDTH-1:0] a_q, a_d;          // multiplicand, shifted left each step
  logic [WIDTH-1:0]   b_q, b_d;          // multiplier, shifted right each step
  logic [2*WIDTH-1:0] p_q, p_d;          // running partial product
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               in_neg;
  logic [WIDTH-1:0]   in_mag;

  // Magnitude of the incoming operand. For -2^(WIDTH-1) the negation wraps
  // back to 2^(WIDTH-1), which is exactly right when read as unsigned.
  assign in_neg = mode_q & data_in[WIDTH-1];
  assign in_mag = in_neg ? (~data_in + 1'b1) : data_in;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LDA;
          mode_d    = signed_en;
          // Clearing here makes product read 0 for the whole of LDA.
          p_d       = '0;
          product_d = '0;
        end
      end

      S_LDA: begin
        if (in_valid) begin
          a_d     = {{WIDTH{1'b0}}, in_mag};
          neg_a_d = in_neg;
          state_d = S_LDB;
        end
      end

      S_LDB: begin
        if (in_valid) begin
          b_d     = in_mag;
          neg_b_d = in_neg;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (b_q == '0) begin
          state_d = S_FIX;
        end else begin
          if (b_q[0]) p_d = p_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
      end

      S_FIX: begin
        // Negating zero yields zero, so a zero operand never gives -0.
        p_d       = (neg_a_q ^ neg_b_q) ? (~p_q + 1'b1) : p_q;
        product_d = p_d;
        state_d   = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      product_q <= product_d;
    end
  end

  assign busy        = (state_q == S_LDA) || (state_q == S_LDB) ||
                       (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_shift_add_ctrl
//   Self-checking bench for mul_shift_add_ctrl (WIDTH=16). Expected products
//   come from plain integer multiplication; expected latency comes from the
//   bit length of the multiplier magnitude plus fixed state overheads.
// -----------------------------------------------------------------------------
module tb_mul_shift_add_ctrl;

  localparam int W = 16;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            signed_en;
  logic            in_valid;
  logic [W-1:0]    data_in;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;
  logic [2:0]      dbg_state;

  int n_vec;
  int n_bad;

  mul_shift_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_en   (signed_en),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic s);
    longint pa, pb, pr;
    logic [63:0] r;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    pr = pa * pb;
    r  = pr;
    return r[2*W-1:0];
  endfunction

  function automatic int ref_latency(input logic [W-1:0] b, input logic s,
                                     input int sa, input int sb);
    int mag, bl;
    mag = (s && b[W-1]) ? (65536 - int'(b)) : int'(b);
    bl = 0;
    while (mag != 0) begin
      bl++;
      mag = mag / 2;
    end
    // start edge, A edge, B edge, CALC cycles, FIX edge, plus stalls
    return 3 + sa + sb + (bl + 1) + 1;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int sa, input int sb,
                        input logic pulse_busy,
                        output logic [2*W-1:0] prod, output int lat,
                        output logic [2*W-1:0] lda_prod, output logic lda_busy,
                        output logic timeout, output logic after_done);
    start     = 1'b1;
    signed_en = s;
    in_valid  = 1'($urandom_range(0, 1));
    data_in   = W'($urandom);
    tick();
    start    = 1'b0;
    lat      = 1;
    lda_prod = product;
    lda_busy = busy;
    repeat (sa) begin
      in_valid = 1'b0;
      data_in  = W'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b1;
    data_in  = a;
    tick();
    lat++;
    repeat (sb) begin
      in_valid = 1'b0;
      data_in  = W'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b1;
    data_in  = b;
    tick();
    lat++;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      start    = pulse_busy && (i == 0);
      in_valid = 1'($urandom_range(0, 1));
      data_in  = W'($urandom);
      tick();
      lat++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    prod     = product;
    tick();
    after_done = done | busy;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_en = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (2) tick();
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_vec++;
    if (product !== '0) begin n_bad++; $display("FAIL reset_product got=%h exp=0", product); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input int sa, input int sb, input logic pulse);
    logic [2*W-1:0] prod, lda_prod, exp_p;
    int lat, exp_l;
    logic lda_busy, timeout, after_done;
    exp_p = ref_product(a, b, s);
    exp_l = ref_latency(b, s, sa, sb);
    run_op(a, b, s, sa, sb, pulse, prod, lat, lda_prod, lda_busy, timeout, after_done);
    n_vec++;
    if (timeout) begin
      n_bad++;
      $display("FAIL %s_timeout a=%h b=%h s=%0b no done within budget", name, a, b, s);
    end
    n_vec++;
    if (prod !== exp_p) begin
      n_bad++;
      $display("FAIL %s_product a=%h b=%h s=%0b got=%h exp=%h", name, a, b, s, prod, exp_p);
    end
    n_vec++;
    if (lat !== exp_l) begin
      n_bad++;
      $display("FAIL %s_latency a=%h b=%h got=%0d exp=%0d", name, a, b, lat, exp_l);
    end
    n_vec++;
    if (lda_prod !== '0 || lda_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_lda product=%h busy=%0b exp product=0 busy=1", name, lda_prod, lda_busy);
    end
    n_vec++;
    if (after_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_after_done done|busy=%0b exp=0", name, after_done);
    end
  endtask

  task automatic test_basic();
    check_op("basic_17x5", 16'd17, 16'd5, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_signed();
    check_op("signed_m3x7", 16'hFFFD, 16'd7, 1'b1, 0, 0, 1'b0);
    check_op("signed_min_sq", 16'h8000, 16'h8000, 1'b1, 0, 0, 1'b0);
    check_op("signed_neg_zero", 16'hFFF0, 16'd0, 1'b1, 0, 0, 1'b0);
    check_op("signed_zero_neg", 16'd0, 16'hFFFF, 1'b1, 0, 0, 1'b0);
    check_op("signed_uns_view", 16'hFFFD, 16'd7, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_boundary();
    check_op("max_sq", 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 1'b0);
    check_op("times_zero", 16'd1234, 16'd0, 1'b0, 0, 0, 1'b0);
    check_op("times_one", 16'hBEEF, 16'd1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    check_op("stall_3_2", 16'd17, 16'd5, 1'b0, 3, 2, 1'b0);
    check_op("start_while_busy", 16'd300, 16'd201, 1'b0, 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; signed_en = 1'b0; in_valid = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1; data_in = 16'h1234;
    tick();
    data_in = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || product !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async busy=%0b product=%h exp busy=0 product=0", busy, product);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      tick();
      if (done || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet active_cycles=%0d exp=0", seen);
    end
    check_op("after_reset_6x7", 16'd6, 16'd7, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_hold();
    logic [2*W-1:0] held;
    int bad;
    check_op("hold_setup", 16'd1000, 16'd999, 1'b0, 0, 0, 1'b0);
    held = product;
    bad = 0;
    repeat (6) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = W'($urandom);
      tick();
      if (product !== 32'd999000) bad++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL hold_product got=%h exp=%h bad_cycles=%0d", held, 32'd999000, bad);
    end
  endtask

  task automatic test_start_in_done();
    logic [2*W-1:0] prod;
    int i;
    start = 1'b1; signed_en = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1; data_in = 16'd3;
    tick();
    data_in = 16'd4;
    tick();
    in_valid = 1'b0;
    i = 0;
    while (!done && i < 40) begin
      tick();
      i++;
    end
    start = 1'b1;
    prod = product;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || prod !== 32'd12) begin
      n_bad++;
      $display("FAIL start_in_done busy=%0b product=%h exp busy=0 product=0000000c", busy, prod);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (k % 8 == 0) b = W'($urandom_range(0, 3));
      check_op("random", a, b, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_signed();
    test_boundary();
    test_stall();
    test_reset_mid();
    test_hold();
    test_start_in_done();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
